mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, word width (fixed 32); NUM_WORDS, 1024, RAM depth in words; ADDR_W, $clog2(NUM_WORDS), RAM word-address width.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  pipeline memory request present.
REQ-005 req_ready  out  1  unit can accept a request.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-009 req_addr  in  32  byte address, little-endian.
REQ-010 req_wdata  in  32  store data, right-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse, loads and stores.
REQ-012 rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  request rejected without RAM access.
REQ-014 ram_addr  out  ADDR_W  word address to single-port RAM.
REQ-015 ram_wren / ram_rden  out  1 each  RAM write / read strobes.
REQ-016 ram_data_in  out  32  RAM write data.
REQ-017 ram_data_out  in  32  RAM read data, registered by the RAM (valid the cycle after ram_rden).

Function
REQ-018 States SHALL be IDLE, RD, WR, MRG, FMT, RSP; req_ready SHALL be 1 only in IDLE.
REQ-019 Acceptance SHALL occur on an edge with req_valid&&req_ready; request fields SHALL be registered then, ram_addr = req_addr[ADDR_W+1:2].
REQ-020 Load: IDLE->RD (ram_rden=1)->FMT (extract lane by addr[1:0], extend, register)->RSP; rsp_valid high the third cycle after acceptance.
REQ-021 Word store: IDLE->WR (ram_wren=1, ram_data_in=wdata)->RSP.
REQ-022 Byte/halfword store: IDLE->RD->MRG (ram_wren=1, ram_data_in = ram_data_out with target lane(s) replaced)->RSP; no byte-enable on RAM, read-modify-write is mandatory.
REQ-023 RSP SHALL last exactly one cycle then return to IDLE; no back-to-back acceptance in RSP.
REQ-024 ram_rden and ram_wren SHALL never be high in the same cycle, and SHALL be 0 in IDLE, FMT, RSP.
REQ-025 req_size=11 or word index >= NUM_WORDS SHALL go IDLE->RSP with rsp_err=1 and no RAM strobe.
REQ-026 rsp_rdata and rsp_err SHALL hold their values only while rsp_valid=1 and be 0 otherwise.

Reset
REQ-027 rst_n low SHALL force IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_wren=0, ram_rden=0 immediately, independent of clk.
REQ-028 Reset mid-operation SHALL abandon the request with no response; a write not yet clocked SHALL not occur.

Configuration
REQ-029 With MEM_ACCESS_MISALIGN_CHK_EN defined, halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL complete as an error per REQ-025.
REQ-030 Without MEM_ACCESS_MISALIGN_CHK_EN, misaligned low address bits SHALL be forced to 0 (halfword: addr[0], word: addr[1:0]) and the access performed normally.

Structure
REQ-031 Package mem_access_pkg SHALL hold the size encoding enum, the state enum, and lane-extract/merge functions.
REQ-032 One sub-module, mem_access_lane (combinational lane extract, extend, merge), SHALL be instantiated once.

Verification
REQ-033 Store word 0xDEADBEEF at 0x10, load word 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after load acceptance.
REQ-034 Word 0x11223344 at 0x20, store byte 0xAA to 0x22 -> RAM word 0x11AA3344, exactly one RD and one WR strobe.
REQ-035 Word 0x80FF0000 at 0x30, signed halfword load 0x32 -> 0xFFFF80FF; unsigned -> 0x000080FF.
REQ-036 req_size=11 at 0x40 -> rsp_err=1, rsp_rdata=0, no RAM strobe; with CHK_EN, halfword at 0x41 -> rsp_err=1; without, accesses 0x40.
REQ-037 rst_n low during MRG of a byte store -> ram_wren drops immediately, RAM word unchanged, no rsp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the memory access unit.
// Holds the access-size encoding, the controller state encoding and the
// little-endian lane extract/merge functions used by mem_access_lane.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_MRG,
        S_FMT,
        S_RSP
    } state_e;

    // Pull the addressed byte/halfword out of a word and sign/zero extend it.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input size_e       size,
        input logic        is_unsigned
    );
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = is_unsigned ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane(s) of the old word with right-aligned store data.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input size_e       size
    );
        logic [31:0] mask;
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (old_word & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/mem_access_lane.sv
// Combinational lane datapath: load extract/extend and store merge.
import mem_access_pkg::*;

module mem_access_lane (
    input  logic [31:0] ram_word,
    input  logic [31:0] store_data,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    assign load_data  = lane_extract(ram_word, offset, size, is_unsigned);
    assign merge_data = lane_merge(ram_word, store_data, offset, size);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-port word RAM with registered read.
// Sub-word stores are done as read-modify-write since the RAM has no byte enables.
// Optional build macro MEM_ACCESS_MISALIGN_CHK_EN: misaligned halfword/word
// accesses are rejected as errors; without it the low address bits are dropped.
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready high
// S_RD   | RAM read strobe issued (loads and sub-word stores)
// S_WR   | RAM write strobe for a full-word store
// S_MRG  | RAM write of read data merged with the store lane(s)
// S_FMT  | extract/extend load data into the response register
// S_RSP  | one-cycle response pulse
import mem_access_pkg::*;

module mem_access_unit #(
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic              ram_rden,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    size_e               size_q, size_d;
    logic                uns_q, uns_d;
    logic [1:0]          off_q, off_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rden_q, rden_d;
    logic                wren_q, wren_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    size_e               size_in;
    logic [1:0]          off_in;
    logic                oob_err;
    logic                misalign_err;
    logic                req_err;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   merge_data;

    assign size_in = size_e'(req_size);
    assign oob_err = ({2'b00, req_addr[31:2]} >= 32'(NUM_WORDS));

`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    assign misalign_err = ((size_in == SZ_HALF) && req_addr[0]) ||
                          ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_err = 1'b0;
`endif

    assign req_err = (size_in == SZ_ILL) || oob_err || misalign_err;

    // Lane offset with the bits below the access size dropped.
    always_comb begin
        case (size_in)
            SZ_HALF: off_in = {req_addr[1], 1'b0};
            SZ_WORD: off_in = 2'b00;
            default: off_in = req_addr[1:0];
        endcase
    end

    mem_access_lane u_lane (
        .ram_word    (ram_data_out),
        .store_data  (wdata_q),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // Next-state, request capture and registered strobe/response values.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        addr_d      = addr_q;
        rden_d      = 1'b0;
        wren_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = size_in;
                    uns_d   = req_unsigned;
                    off_d   = off_in;
                    wdata_d = req_wdata;
                    addr_d  = req_addr[ADDR_W+1:2];
                    if (req_err) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (req_we && (size_in == SZ_WORD)) begin
                        state_d = S_WR;
                        wren_d  = 1'b1;
                    end else begin
                        state_d = S_RD;
                        rden_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (we_q) begin
                    state_d = S_MRG;
                    wren_d  = 1'b1;
                end else begin
                    state_d = S_FMT;
                end
            end
            S_WR, S_MRG: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
            end
            S_FMT: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_data;
            end
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears strobes and response at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            addr_q      <= '0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Merge data depends on the RAM read that lands during S_MRG, so it stays combinational.
    assign ram_data_in = (state_q == S_MRG) ? merge_data : wdata_q;

    assign req_ready = (state_q == S_IDLE);
    assign ram_addr  = addr_q;
    assign ram_rden  = rden_q;
    assign ram_wren  = wren_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural registered-read RAM.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  ram_addr;
    logic        ram_wren;
    logic        ram_rden;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic overlap_seen = 1'b0;
    logic idle_dirty   = 1'b0;
    logic [32:0] sb_q[$];
    logic [31:0] mem [0:1023];
    logic [31:0] sh [8];

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_wren     (ram_wren),
        .ram_rden     (ram_rden),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rden) ram_data_out <= mem[ram_addr];
        if (ram_wren) mem[ram_addr] <= ram_data_in;
        if (ram_rden) rd_cnt++;
        if (ram_wren) wr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (ram_rden && ram_wren) overlap_seen = 1'b1;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("rsp_rdata", rsp_rdata, e[31:0]);
                check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end else if ((rsp_rdata != 32'd0) || rsp_err) begin
            idle_dirty = 1'b1;
        end
    end

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic u);
        int o;
        logic [31:0] v;
        o = 8 * int'(off);
        case (sz)
            2'b00:   v = u ? {24'h0, w[o +: 8]}  : {{24{w[o+7]}}, w[o +: 8]};
            2'b01:   v = u ? {16'h0, w[o +: 16]} : {{16{w[o+15]}}, w[o +: 16]};
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] off, input logic [1:0] sz);
        int o;
        logic [31:0] v;
        o = 8 * int'(off);
        v = w;
        case (sz)
            2'b00:   v[o +: 8]  = d[7:0];
            2'b01:   v[o +: 16] = d[15:0];
            default: v = d;
        endcase
        return v;
    endfunction

    // Issue one request, push its expected response, then check completion latency.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [32:0] exp, input int lat, input string tag);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = addr;
        req_wdata    = wd;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check_eq({tag, "_latency"}, 32'(n), 32'(lat));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd0, wr0;
        logic        we;
        logic [1:0]  sz, off;
        logic        u;
        logic [2:0]  wi;
        logic [31:0] d;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_strobes", {30'd0, ram_wren, ram_rden}, 32'd0);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, {1'b0, 32'h0}, 2, "st_word");
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, {1'b0, 32'hDEADBEEF}, 3, "ld_word");

        // byte store read-modify-write
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, {1'b0, 32'h0}, 2, "st_word20");
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, {1'b0, 32'h0}, 3, "st_byte");
        check_eq("rmw_rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        check_eq("rmw_wr_strobes", 32'(wr_cnt - wr0), 32'd1);
        check_eq("rmw_ram_word", mem[8], 32'h11AA3344);

        // halfword and byte loads with both extensions
        do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF0000, {1'b0, 32'h0}, 2, "st_word30");
        do_req(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, {1'b0, 32'hFFFF80FF}, 3, "ld_half_s");
        do_req(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, {1'b0, 32'h000080FF}, 3, "ld_half_u");
        do_req(1'b0, 2'b00, 1'b0, 32'h33, 32'h0, {1'b0, 32'hFFFFFF80}, 3, "ld_byte_s");
        do_req(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, {1'b0, 32'h00000000}, 3, "ld_byte_u");

        // illegal size and out-of-range address
        rd0 = rd_cnt; wr0 = wr_cnt;
        do_req(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, {1'b1, 32'h0}, 1, "ill_size");
        do_req(1'b1, 2'b10, 1'b0, 32'h1000, 32'h12345678, {1'b1, 32'h0}, 1, "oob");
        check_eq("err_no_strobes", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

        // misaligned halfword
        do_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, {1'b0, 32'h0}, 2, "st_word40");
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
        do_req(1'b0, 2'b01, 1'b1, 32'h41, 32'h0, {1'b1, 32'h0}, 1, "misalign_half");
`else
        do_req(1'b0, 2'b01, 1'b1, 32'h41, 32'h0, {1'b0, 32'h00005678}, 3, "misalign_half");
`endif

        // randomized traffic against a shadow of words 0x100..0x11C
        for (int i = 0; i < 8; i++) begin
            sh[i] = $urandom;
            do_req(1'b1, 2'b10, 1'b0, 32'h100 + 32'(4 * i), sh[i], {1'b0, 32'h0}, 2, "rnd_init");
        end
        for (int i = 0; i < 24; i++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 2));
            u   = 1'($urandom_range(0, 1));
            wi  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            if (sz == 2'b01) off[0] = 1'b0;
            if (sz == 2'b10) off = 2'b00;
            d = $urandom;
            if (we) begin
                do_req(1'b1, sz, u, 32'h100 + {27'd0, wi, off}, d, {1'b0, 32'h0},
                       (sz == 2'b10) ? 2 : 3, "rnd_st");
                sh[wi] = m_store(sh[wi], d, off, sz);
            end else begin
                do_req(1'b0, sz, u, 32'h100 + {27'd0, wi, off}, 32'h0,
                       {1'b0, m_load(sh[wi], off, sz, u)}, 3, "rnd_ld");
            end
        end
        for (int i = 0; i < 8; i++) check_eq("rnd_ram_word", mem[64 + i], sh[i]);

        // reset during the merge write of a byte store
        do_req(1'b1, 2'b10, 1'b0, 32'h50, 32'h55667788, {1'b0, 32'h0}, 2, "st_word50");
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h50;
        req_wdata    = 32'h99;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mrg_wren", {31'd0, ram_wren}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mrg_wren", {31'd0, ram_wren}, 32'd0);
        check_eq("rst_mrg_rsp", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mrg_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_mrg_ram", mem[20], 32'h55667788);
        do_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, {1'b0, 32'h55667788}, 3, "ld_after_rst");

        repeat (2) @(negedge clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        check_eq("no_strobe_overlap", {31'd0, overlap_seen}, 32'd0);
        check_eq("rsp_zero_when_idle", {31'd0, idle_dirty}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
